// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD line arbiter.
package lcd_pkg;

    localparam int LCD_LINE_LEN = 16;
    localparam int LCD_CHAR_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } lcd_state_e;

endpackage

// File: rtl/lcd_line_arbiter_if.sv
// Client-side and writer-side signals of the LCD line arbiter.
interface lcd_line_arbiter_if;
    import lcd_pkg::*;

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [1:0]            done;
    logic [3:0]            rd_idx;
    logic [LCD_CHAR_W-1:0] char0;
    logic [LCD_CHAR_W-1:0] char1;
    logic                  start_update;
    logic                  valid_o;
    logic [LCD_CHAR_W-1:0] char_o;
    logic                  lcd_busy;

    modport master (
        input  req, char0, char1, lcd_busy,
        output gnt, done, rd_idx, start_update, valid_o, char_o
    );

    modport slave (
        output req, char0, char1, lcd_busy,
        input  gnt, done, rd_idx, start_update, valid_o, char_o
    );

endinterface

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin picker; on a tie the client not granted last wins.
module lcd_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/lcd_line_arbiter.sv
// Grants the LCD writer to one of two clients per line and streams
// that client's line buffer as paced single-cycle char beats.
module lcd_line_arbiter
    import lcd_pkg::*;
#(
    parameter int LINE_LEN   = LCD_LINE_LEN,
    parameter int GAP_CYCLES = 2
) (
    input logic                CLK,
    input logic                RST,
    lcd_line_arbiter_if.master bus
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [3:0]    IDX_LAST = 4'(LINE_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    lcd_state_e            state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic [3:0]            idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [1:0]            done_q, done_d;
    logic                  su_q, su_d;
    logic                  valid_q, valid_d;
    logic [LCD_CHAR_W-1:0] char_q, char_d;
    logic [1:0]            pick;
    logic [LCD_CHAR_W-1:0] char_sel;

    lcd_rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .en   (state_q == ST_IDLE),
        .gnt  (pick)
    );

    assign char_sel = gnt_q[1] ? bus.char1 : bus.char0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            idx_q   <= 4'd0;
            gap_q   <= '0;
            done_q  <= 2'b00;
            su_q    <= 1'b0;
            valid_q <= 1'b0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            su_q    <= su_d;
            valid_q <= valid_d;
            char_q  <= char_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        done_d  = 2'b00;
        su_d    = 1'b0;
        valid_d = 1'b0;
        char_d  = char_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    state_d = ST_START;
                    gnt_d   = pick;
                    last_d  = pick[1];
                    idx_d   = 4'd0;
                end
            end
            ST_START: begin
                su_d    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!bus.lcd_busy) begin
                    valid_d = 1'b1;
                    char_d  = char_sel;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        done_d  = gnt_q;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            // Idle spacing lets the writer raise busy before the next sample.
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.rd_idx       = idx_q;
    assign bus.start_update = su_q;
    assign bus.valid_o      = valid_q;
    assign bus.char_o       = char_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Directed bench for lcd_line_arbiter: single line, contention,
// busy pacing, request withdrawal and mid-line reset.
module tb_lcd_line_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    lcd_line_arbiter_if bus ();

    lcd_line_arbiter #(
        .LINE_LEN   (16),
        .GAP_CYCLES (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    assign bus.char0 = 8'h41 + {4'd0, bus.rd_idx};
    assign bus.char1 = 8'h61 + {4'd0, bus.rd_idx};

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    logic       busy_q = 1'b0;
    logic [7:0] beats[$];
    int         bcyc[$];
    logic [1:0] gq[$];
    int         su_cnt = 0;
    int         su_cyc = 0;
    int         d0 = 0;
    int         d1 = 0;
    int         viol = 0;

    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        busy_q <= bus.lcd_busy;
    end

    always @(negedge CLK) begin
        if (bus.valid_o) begin
            beats.push_back(bus.char_o);
            bcyc.push_back(cyc);
            if (busy_q) viol++;
        end
        if (bus.start_update) begin
            su_cnt++;
            su_cyc = cyc;
            gq.push_back(bus.gnt);
        end
        if (bus.done[0]) d0++;
        if (bus.done[1]) d1++;
        if (bus.valid_o && bus.start_update) viol++;
        if (!$onehot0(bus.gnt)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic wait_done(input int which, input int max);
        int n = 0;
        while (!bus.done[which] && n < max) begin
            step(1);
            n++;
        end
        chk("done_seen", 32'(bus.done[which]), 32'd1);
    endtask

    task automatic wait_beats(input int target, input int max);
        int n = 0;
        while (beats.size() < target && n < max) begin
            step(1);
            n++;
        end
        chk("beat_seen", 32'(beats.size() >= target), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt),          32'd0);
        chk({tag, "_done"},  32'(bus.done),         32'd0);
        chk({tag, "_su"},    32'(bus.start_update), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid_o),      32'd0);
        chk({tag, "_char"},  32'(bus.char_o),       32'd0);
        chk({tag, "_idx"},   32'(bus.rd_idx),       32'd0);
    endtask

    task automatic chk_line(input string tag, input int b, input int base);
        for (int i = 0; i < 16; i++) begin
            chk(tag, 32'(beats[b + i]), 32'(base + i));
        end
    endtask

    initial begin
        int b, s, e0, e1, g, n;
        bus.req      = 2'b00;
        bus.lcd_busy = 1'b0;
        step(2);
        chk_reset_vals("rst");
        RST = 1'b0;

        // single request, free-running writer
        b = beats.size(); s = su_cnt; e0 = d0;
        bus.req = 2'b01;
        step(1);
        chk("t1_gnt", 32'(bus.gnt), 32'd1);
        bus.req = 2'b00;
        step(1);
        chk("t1_su", 32'(bus.start_update), 32'd1);
        wait_done(0, 200);
        step(1);
        chk("t1_gnt_clr", 32'(bus.gnt), 32'd0);
        chk("t1_beats", 32'(beats.size() - b), 32'd16);
        chk("t1_su_cnt", 32'(su_cnt - s), 32'd1);
        chk("t1_done_cnt", 32'(d0 - e0), 32'd1);
        chk("t1_first_lat", 32'(bcyc[b] - su_cyc), 32'd1);
        chk_line("t1_char", b, 'h41);
        for (int i = 1; i < 16; i++) begin
            chk("t1_space", 32'(bcyc[b + i] - bcyc[b + i - 1]), 32'd3);
        end

        // contention from reset: 01, 10, 01
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        b = beats.size(); s = su_cnt; g = gq.size();
        e0 = d0; e1 = d1; n = 0;
        bus.req = 2'b11;
        while ((d0 - e0) + (d1 - e1) < 3 && n < 600) begin
            step(1);
            n++;
        end
        bus.req = 2'b00;
        chk("t2_lines", 32'((d0 - e0) + (d1 - e1)), 32'd3);
        step(2);
        chk("t2_su_cnt", 32'(su_cnt - s), 32'd3);
        chk("t2_beats", 32'(beats.size() - b), 32'd48);
        chk("t2_g0", 32'(gq[g]),     32'd1);
        chk("t2_g1", 32'(gq[g + 1]), 32'd2);
        chk("t2_g2", 32'(gq[g + 2]), 32'd1);
        chk_line("t2_l0", b,      'h41);
        chk_line("t2_l1", b + 16, 'h61);
        chk_line("t2_l2", b + 32, 'h41);

        // busy held five cycles after the third beat
        b = beats.size();
        bus.req = 2'b01;
        step(1);
        bus.req = 2'b00;
        wait_beats(b + 3, 100);
        bus.lcd_busy = 1'b1;
        step(5);
        bus.lcd_busy = 1'b0;
        wait_done(0, 200);
        step(1);
        chk("t3_beats", 32'(beats.size() - b), 32'd16);
        chk("t3_stall", 32'(bcyc[b + 3] - bcyc[b + 2]), 32'd6);
        chk("t3_after", 32'(bcyc[b + 4] - bcyc[b + 3]), 32'd3);
        chk_line("t3_char", b, 'h41);
        chk("t3_viol", 32'(viol), 32'd0);

        // request withdrawn after two beats
        b = beats.size(); e0 = d0;
        bus.req = 2'b01;
        wait_beats(b + 2, 100);
        bus.req = 2'b00;
        wait_done(0, 200);
        step(1);
        chk("t4_beats", 32'(beats.size() - b), 32'd16);
        chk("t4_done_cnt", 32'(d0 - e0), 32'd1);
        chk("t4_last", 32'(beats[b + 15]), 32'h50);

        // reset mid-line after seven beats
        b = beats.size(); e0 = d0; e1 = d1;
        bus.req = 2'b01;
        step(1);
        bus.req = 2'b00;
        wait_beats(b + 7, 100);
        RST = 1'b1;
        #1;
        chk_reset_vals("t5_rst");
        step(3);
        chk("t5_partial", 32'(beats.size() - b), 32'd7);
        chk("t5_no_done", 32'((d0 - e0) + (d1 - e1)), 32'd0);
        bus.req = 2'b01;
        RST = 1'b0;
        b = beats.size(); s = su_cnt;
        step(1);
        chk("t5_regnt", 32'(bus.gnt), 32'd1);
        chk("t5_idx0", 32'(bus.rd_idx), 32'd0);
        bus.req = 2'b00;
        step(1);
        chk("t5_su", 32'(bus.start_update), 32'd1);
        wait_done(0, 200);
        step(1);
        chk("t5_beats", 32'(beats.size() - b), 32'd16);
        chk("t5_first", 32'(beats[b]), 32'h41);
        chk("t5_su_cnt", 32'(su_cnt - s), 32'd1);
        chk("final_viol", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
